// File: rtl/sirv_qspi_flash_seq.sv
// ---------------------------------------------------------------------------
// sirv_qspi_flash_seq
//
// Runs one QSPI flash read sequence through the QSPI controller's register
// port over ICB: hold chip-select, shift out cmd + 24-bit address, then
// shift `len` dummy bytes while collecting the returned data bytes, and
// finally release chip-select back to auto mode.
//
// Every byte on the wire is one txdata write followed by rxdata polling
// until the controller reports a non-empty FIFO. Only one ICB transaction
// is ever outstanding.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   start                 : one-cycle request, honoured only when idle
//   cmd / addr / len      : flash command, address, data byte count
//                           (captured when start is accepted)
//   busy                  : sequence in progress (low in IDLE and DONE)
//   done / err            : end-of-sequence pulse, err = poll timeout
//   rx_valid / rx_data    : one pulse per received data byte
//   o_icb_cmd_*           : ICB command channel to QSPI registers
//   o_icb_rsp_*           : ICB response channel from QSPI registers
// ---------------------------------------------------------------------------
module sirv_qspi_flash_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_4000,
  parameter int unsigned POLL_MAX  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        o_icb_cmd_valid,
  input  logic        o_icb_cmd_ready,
  output logic [31:0] o_icb_cmd_addr,
  output logic        o_icb_cmd_read,
  output logic [31:0] o_icb_cmd_wdata,
  input  logic        o_icb_rsp_valid,
  output logic        o_icb_rsp_ready,
  input  logic [31:0] o_icb_rsp_rdata
);

  localparam logic [31:0] CSMODE_ADDR = BASE_ADDR + 32'h18;
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + 32'h48;
  localparam logic [31:0] RXDATA_ADDR = BASE_ADDR + 32'h4C;

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  // Poll count value at which one more empty read means timeout.
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_HOLD,
    TX,
    RX,
    CS_AUTO,
    DONE
  } state_t;

  state_t        state, state_nxt;
  // Low: command phase of the current register access; high: awaiting response.
  logic          wait_rsp, wait_rsp_nxt;

  logic [7:0]    cmd_r;
  logic [23:0]   addr_r;
  logic [7:0]    len_r;
  // 9 bits so that 3 + 255 is reachable without wrapping.
  logic [8:0]    idx;
  logic [PW-1:0] poll_cnt;
  logic          err_r;

  logic          cmd_hs;
  logic          rsp_hs;
  logic          rx_empty;
  logic          byte_last;
  logic          poll_last;
  logic          start_acc;
  logic          rsp_unused;

  assign cmd_hs     = o_icb_cmd_valid & o_icb_cmd_ready;
  assign rsp_hs     = o_icb_rsp_ready & o_icb_rsp_valid;
  assign rx_empty   = o_icb_rsp_rdata[31];
  assign byte_last  = (idx == (9'd3 + {1'b0, len_r}));
  assign poll_last  = (poll_cnt == POLL_LAST);
  assign start_acc  = (state == IDLE) && start;
  assign rsp_unused = ^o_icb_rsp_rdata[30:8];

  // Byte placed on the wire for a given index: command, address MSB first,
  // then zero dummies that clock the data bytes back in.
  function automatic logic [7:0] tx_byte_sel(input logic [8:0] i,
                                             input logic [7:0] c,
                                             input logic [23:0] a);
    case (i)
      9'd0:    return c;
      9'd1:    return a[23:16];
      9'd2:    return a[15:8];
      9'd3:    return a[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // ---- control state register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_rsp <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_rsp <= wait_rsp_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_rsp_nxt = wait_rsp;
    case (state)
      IDLE: begin
        wait_rsp_nxt = 1'b0;
        if (start) state_nxt = CS_HOLD;
      end
      CS_HOLD, TX, RX, CS_AUTO: begin
        if (!wait_rsp) begin
          if (cmd_hs) wait_rsp_nxt = 1'b1;
        end else if (rsp_hs) begin
          wait_rsp_nxt = 1'b0;
          case (state)
            CS_HOLD: state_nxt = TX;
            TX:      state_nxt = RX;
            RX: begin
              if (rx_empty) state_nxt = poll_last ? CS_AUTO : RX;
              else          state_nxt = byte_last ? CS_AUTO : TX;
            end
            CS_AUTO: state_nxt = DONE;
            default: state_nxt = IDLE;
          endcase
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- ICB command decode ----
  always_comb begin
    o_icb_cmd_addr  = 32'h0;
    o_icb_cmd_read  = 1'b0;
    o_icb_cmd_wdata = 32'h0;
    o_icb_cmd_valid = 1'b0;
    case (state)
      CS_HOLD: begin
        o_icb_cmd_addr  = CSMODE_ADDR;
        o_icb_cmd_wdata = 32'h2;
        o_icb_cmd_valid = !wait_rsp;
      end
      TX: begin
        o_icb_cmd_addr  = TXDATA_ADDR;
        o_icb_cmd_wdata = {24'h0, tx_byte_sel(idx, cmd_r, addr_r)};
        o_icb_cmd_valid = !wait_rsp;
      end
      RX: begin
        o_icb_cmd_addr  = RXDATA_ADDR;
        o_icb_cmd_read  = 1'b1;
        o_icb_cmd_valid = !wait_rsp;
      end
      CS_AUTO: begin
        o_icb_cmd_addr  = CSMODE_ADDR;
        o_icb_cmd_wdata = 32'h0;
        o_icb_cmd_valid = !wait_rsp;
      end
      default: ;
    endcase
  end

  assign o_icb_rsp_ready = wait_rsp;
  assign busy            = (state != IDLE) && (state != DONE);
  assign done            = (state == DONE);
  assign err             = err_r;

  // ---- request capture ----
  always_ff @(posedge clock) begin
    if (start_acc) begin
      cmd_r  <= cmd;
      addr_r <= addr;
      len_r  <= len;
    end
  end

  // ---- byte index, poll counter, receive output ----
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= 9'd0;
      poll_cnt <= '0;
      err_r    <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      if (start_acc) begin
        idx   <= 9'd0;
        err_r <= 1'b0;
      end
      if ((state == TX) && wait_rsp && rsp_hs) poll_cnt <= '0;
      if ((state == RX) && wait_rsp && rsp_hs) begin
        if (rx_empty) begin
          poll_cnt <= poll_cnt + PW'(1);
          if (poll_last) err_r <= 1'b1;
        end else begin
          // Bytes 0..3 are clocked in while cmd/addr go out and carry no data.
          if (idx >= 9'd4) begin
            rx_valid <= 1'b1;
            rx_data  <= o_icb_rsp_rdata[7:0];
          end
          if (!byte_last) idx <= idx + 9'd1;
        end
      end
    end
  end

endmodule
